// File: rtl/pkt_fifo_pkg.sv
// Shared types and width helpers for the packet FIFO.
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_FILL    = 2'd1,
        W_DISCARD = 2'd2
    } wstate_t;

    // Bits needed to index 'value' distinct items, never less than one.
    function automatic int width_of(input int value);
        return (value < 32'sd2) ? 32'sd1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Unit storage and per-entry length array: one write port, one combinational read port.
module pkt_fifo_mem #(
    parameter int DEPTH  = 3,
    parameter int WIDTH  = 11,
    parameter int UWIDTH = 8,
    parameter int PW     = 2,
    parameter int IW     = 4,
    parameter int LW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [IW-1:0]     widx,
    input  logic [UWIDTH-1:0] wdata,
    input  logic              len_we,
    input  logic [LW-1:0]     len_data,
    input  logic [PW-1:0]     raddr,
    input  logic [IW-1:0]     ridx,
    output logic [UWIDTH-1:0] rdata,
    output logic [LW-1:0]     rlen
);

    logic [UWIDTH-1:0] mem_r [DEPTH][WIDTH];
    logic [LW-1:0]     len_r [DEPTH];

    // Storage is deliberately left unreset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr][widx] <= wdata;
        end
        if (len_we) begin
            len_r[waddr] <= len_data;
        end
    end

    assign rdata = mem_r[raddr][ridx];
    assign rlen  = len_r[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO with truncation of oversize packets; optional write abort via PKT_FIFO_ABORT_EN.
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int WIDTH  = 11,
    parameter int UWIDTH = 8,
    parameter int AFULL  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [UWIDTH-1:0]            wr_data,
    input  logic                         wr_last,
    output logic                         wr_ready,
    input  logic                         wr_abort,
    output logic                         rd_valid,
    output logic [UWIDTH-1:0]            rd_data,
    output logic                         rd_last,
    input  logic                         rd_ready,
    output logic [width_of(DEPTH+1)-1:0] count,
    output logic                         wfull,
    output logic                         rempty,
    output logic                         afull,
    output logic                         ovf_err
);

    localparam int PW = width_of(DEPTH);
    localparam int IW = width_of(WIDTH);
    localparam int LW = width_of(WIDTH + 1);
    localparam int CW = width_of(DEPTH + 1);

    wstate_t       state_r;
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [IW-1:0] widx_r;
    logic [IW-1:0] ridx_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;

    logic          abort_s;
    logic          wr_fire_s;
    logic          store_s;
    logic          at_limit_s;
    logic          commit_s;
    logic          ovf_s;
    logic          pop_s;
    logic          pop_last_s;
    logic [LW-1:0] wlen_s;
    logic [LW-1:0] rlen_s;
    logic [PW-1:0] wptr_next_s;
    logic [PW-1:0] rptr_next_s;

`ifdef PKT_FIFO_ABORT_EN
    assign abort_s = wr_abort;
`else
    assign abort_s = wr_abort & 1'b0;
`endif

    assign wr_ready   = (count_r < CW'(DEPTH)) || (state_r == W_DISCARD);
    assign wr_fire_s  = wr_valid && wr_ready;
    assign store_s    = wr_fire_s && !abort_s && (state_r != W_DISCARD);
    assign at_limit_s = (widx_r == IW'(WIDTH - 1));
    assign commit_s   = store_s && (wr_last || at_limit_s);
    assign ovf_s      = store_s && !wr_last && at_limit_s;
    assign wlen_s     = wr_last ? (LW'(widx_r) + LW'(1'b1)) : LW'(WIDTH);

    assign wptr_next_s = (wptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : (wptr_r + PW'(1'b1));
    assign rptr_next_s = (rptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : (rptr_r + PW'(1'b1));

    assign rd_valid   = (count_r != {CW{1'b0}});
    assign rd_last    = (LW'(ridx_r) == (rlen_s - LW'(1'b1)));
    assign pop_s      = rd_valid && rd_ready;
    assign pop_last_s = pop_s && rd_last;

    assign count   = count_r;
    assign wfull   = (count_r == CW'(DEPTH));
    assign rempty  = (count_r == {CW{1'b0}});
    assign afull   = (count_r >= CW'(AFULL));
    assign ovf_err = ovf_r;

    pkt_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .UWIDTH (UWIDTH),
        .PW     (PW),
        .IW     (IW),
        .LW     (LW)
    ) u_mem (
        .clk      (clk),
        .we       (store_s),
        .waddr    (wptr_r),
        .widx     (widx_r),
        .wdata    (wr_data),
        .len_we   (commit_s),
        .len_data (wlen_s),
        .raddr    (rptr_r),
        .ridx     (ridx_r),
        .rdata    (rd_data),
        .rlen     (rlen_s)
    );

    // Write FSM: fills the entry at wptr, commits on last or truncation, then drops the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= W_IDLE;
            wptr_r  <= {PW{1'b0}};
            widx_r  <= {IW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            ovf_r <= ovf_s;
            if (abort_s) begin
                state_r <= W_IDLE;
                widx_r  <= {IW{1'b0}};
            end else if (wr_fire_s) begin
                case (state_r)
                    W_IDLE, W_FILL: begin
                        if (commit_s) begin
                            widx_r  <= {IW{1'b0}};
                            wptr_r  <= wptr_next_s;
                            state_r <= wr_last ? W_IDLE : W_DISCARD;
                        end else begin
                            widx_r  <= widx_r + IW'(1'b1);
                            state_r <= W_FILL;
                        end
                    end
                    W_DISCARD: begin
                        if (wr_last) begin
                            state_r <= W_IDLE;
                        end else begin
                            state_r <= W_DISCARD;
                        end
                    end
                    default: begin
                        state_r <= W_IDLE;
                        widx_r  <= {IW{1'b0}};
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Read side: walk units of the entry at rptr, advancing to the next entry on its last unit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_r <= {PW{1'b0}};
            ridx_r <= {IW{1'b0}};
        end else if (pop_s) begin
            if (rd_last) begin
                ridx_r <= {IW{1'b0}};
                rptr_r <= rptr_next_s;
            end else begin
                ridx_r <= ridx_r + IW'(1'b1);
            end
        end else begin
            ridx_r <= ridx_r;
        end
    end

    // Committed-entry count; a commit and an entry pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({commit_s, pop_last_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
